ili_spi_responder: RTL

- Synthesizable 4-wire SPI slave modelling the ILI9341 panel side of the display link, in the same clock domain as the SPI master path.
- Oversamples `sclk`/`cs`/`dc`/`mosi` with the system clock, deserializes bytes tagged as command or parameter, and reports each one with a strobe.
- Answers the Read Display ID command (0x04) on `miso`.
- Used as a loopback target on-board and as the bench responder for the master path.

---
 rtl/pkg_ili9341.sv | 16 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/ili_spi_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_ili9341.sv
// Shared ILI9341 display-link constants and types.
// Used by the SPI responder and its pin synchronizer.
package pkg_ili9341;

    localparam logic [7:0] CMD_RDDID         = 8'h04;
    localparam int         SPI_BITS_PER_BYTE = 8;
    localparam int         RDDID_BITS        = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DUMMY,
        ST_READ
    } resp_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage pin synchronizer with registered-copy edge detect.
// RST_VAL lets idle-high pins such as chip select come up inactive.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = lvl_o & ~dly_q;
    assign fall_o = ~lvl_o & dly_q;

endmodule

// File: rtl/ili_spi_responder.sv
// ILI9341-side SPI mode-0 slave: byte capture, cmd/param tracking, RDDID reply.
// Define ILI_SPI_RESP_READ_EN to build the RDDID read-back path.
module ili_spi_responder
    import pkg_ili9341::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] DISP_ID     = 24'h00_93_41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sclk,
    input  logic       i_cs,
    input  logic       i_dc,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic [7:0] o_byte,
    output logic       o_byte_dc,
    output logic       o_byte_valid,
    output logic [7:0] o_cmd,
    output logic [7:0] o_param_idx,
    output logic       o_busy
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic dc_lvl, dc_rise, dc_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin_i(i_sclk),
        .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin_i(i_cs),
        .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
        .clk(clk), .rst(rst), .pin_i(i_dc),
        .lvl_o(dc_lvl), .rise_o(dc_rise), .fall_o(dc_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin_i(i_mosi),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, dc_rise, dc_fall, mosi_rise, mosi_fall};

    resp_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_dc_q, byte_dc_d;
    logic        valid_q, valid_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  pidx_q, pidx_d;

    logic [7:0]  byte_in;
    logic        last_bit;
    logic        byte_done;

    assign byte_in   = {sh_q, mosi_lvl};
    assign last_bit  = bit_cnt_q == 3'(SPI_BITS_PER_BYTE - 1);
    assign byte_done = (state_q == ST_SHIFT) && sclk_rise && last_bit;

`ifdef ILI_SPI_RESP_READ_EN
    logic        dummy_rise_q, dummy_rise_d;
    logic [4:0]  rd_cnt_q, rd_cnt_d;
    logic [22:0] id_q, id_d;
    logic        miso_q, miso_d;
    logic        rddid_hit;
    logic        rd_last;

    assign rddid_hit = byte_done && !dc_lvl && (byte_in == CMD_RDDID);
    assign rd_last   = rd_cnt_q == 5'(RDDID_BITS - 1);
`else
    logic unused_id;
    assign unused_id = ^DISP_ID;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
`ifdef ILI_SPI_RESP_READ_EN
                    if (rddid_hit) state_d = ST_DUMMY;
`endif
                end
`ifdef ILI_SPI_RESP_READ_EN
                ST_DUMMY: begin
                    if (sclk_fall && dummy_rise_q) state_d = ST_READ;
                end
                ST_READ: begin
                    if (sclk_rise && rd_last) state_d = ST_SHIFT;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        byte_d    = byte_q;
        byte_dc_d = byte_dc_q;
        valid_d   = 1'b0;
        cmd_d     = cmd_q;
        pidx_d    = pidx_q;
        if (cs_rise) begin
            bit_cnt_d = '0;
            sh_d      = '0;
        end else if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT && sclk_rise) begin
            sh_d      = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
                byte_d    = byte_in;
                byte_dc_d = dc_lvl;
                valid_d   = 1'b1;
                if (!dc_lvl) begin
                    cmd_d  = byte_in;
                    pidx_d = '0;
                end else if (pidx_q != 8'hFF) begin
                    pidx_d = pidx_q + 8'd1;
                end
            end
`ifdef ILI_SPI_RESP_READ_EN
        end else if (state_q == ST_READ && sclk_rise && rd_last) begin
            bit_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            sh_q      <= '0;
            byte_q    <= '0;
            byte_dc_q <= 1'b0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            pidx_q    <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            byte_q    <= byte_d;
            byte_dc_q <= byte_dc_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            pidx_q    <= pidx_d;
        end
    end

`ifdef ILI_SPI_RESP_READ_EN
    // The falling edge that ends the RDDID byte itself must not start the ID.
    always_comb begin
        dummy_rise_d = dummy_rise_q;
        rd_cnt_d     = rd_cnt_q;
        id_d         = id_q;
        miso_d       = miso_q;
        if (cs_rise) begin
            dummy_rise_d = 1'b0;
            miso_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_SHIFT: dummy_rise_d = 1'b0;
                ST_DUMMY: begin
                    if (sclk_rise) dummy_rise_d = 1'b1;
                    if (sclk_fall && dummy_rise_q) begin
                        miso_d   = DISP_ID[23];
                        id_d     = DISP_ID[22:0];
                        rd_cnt_d = '0;
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        miso_d = id_q[22];
                        id_d   = {id_q[21:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rd_cnt_d = rd_cnt_q + 5'd1;
                        if (rd_last) miso_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dummy_rise_q <= 1'b0;
            rd_cnt_q     <= '0;
            id_q         <= '0;
            miso_q       <= 1'b0;
        end else begin
            dummy_rise_q <= dummy_rise_d;
            rd_cnt_q     <= rd_cnt_d;
            id_q         <= id_d;
            miso_q       <= miso_d;
        end
    end
`endif

    always_comb begin
        o_byte       = byte_q;
        o_byte_dc    = byte_dc_q;
        o_byte_valid = valid_q;
        o_cmd        = cmd_q;
        o_param_idx  = pidx_q;
        o_busy       = ~cs_lvl;
`ifdef ILI_SPI_RESP_READ_EN
        o_miso       = miso_q;
`else
        o_miso       = 1'b0;
`endif
    end

endmodule
